// File: rtl/somador_bcd_pkg.sv
// -----------------------------------------------------------------------------
// somador_bcd_pkg
// Shared types and constants for the single-digit BCD adder (somador_bcd_1)
// and its combinational digit cell (bcd_digit_add).
// -----------------------------------------------------------------------------
package somador_bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_pair_t;

endpackage

// File: rtl/bcd_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder using decimal (+6) correction.
// Ports:
//   a, b   : addend digits (0..9 nominal; 10..15 tolerated)
//   cin    : decimal carry-in
//   units  : s mod 10
//   tens   : s / 10 (0..3 when non-BCD digits are applied)
//   cout   : 1 when s >= 10
// -----------------------------------------------------------------------------
module bcd_digit_add
    import somador_bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t units,
    output bcd_digit_t tens,
    output logic       cout
);

    logic [4:0] sum_bin;
    logic [1:0] decades;
    logic [5:0] corr;
    logic [5:0] sum_corr;

    always_comb begin
        sum_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

        // Binary sum tops out at 31, so up to three decades can occur with
        // non-BCD digits. Each decade needs one +6 to skip the codes 10..15.
        if (sum_bin >= 5'd30) begin
            decades = 2'd3;
        end else if (sum_bin >= 5'd20) begin
            decades = 2'd2;
        end else if (sum_bin >= 5'd10) begin
            decades = 2'd1;
        end else begin
            decades = 2'd0;
        end

        corr     = {2'b00, BCD_CORR} * {4'b0000, decades};
        sum_corr = {1'b0, sum_bin} + corr;

        units = sum_corr[3:0];
        tens  = {2'b00, decades};
        cout  = (sum_bin > {1'b0, BCD_MAX});
    end

endmodule

// File: rtl/somador_bcd_1.sv
// -----------------------------------------------------------------------------
// somador_bcd_1
// Single-digit BCD adder with a one-cycle registered output stage.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset (priority over in_valid)
//   in_valid  : qualifies A/B/C_in
//   A, B      : BCD addend digits
//   C_in      : decimal carry-in
//   out_valid : one-cycle pulse, saida/carry hold a new result
//   saida     : packed BCD sum {tens, units}
//   carry     : decimal carry-out (sum >= 10)
//   err       : only with SOMADOR_BCD_CHECK_EN defined; flags an accepted
//               non-BCD digit, forcing saida/carry to zero
// Optional build macro: SOMADOR_BCD_CHECK_EN
// -----------------------------------------------------------------------------
module somador_bcd_1
    import somador_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in,
    output logic       out_valid,
    output logic [7:0] saida,
    output logic       carry
`ifdef SOMADOR_BCD_CHECK_EN
    ,
    output logic       err
`endif
);

    bcd_digit_t units_c;
    bcd_digit_t tens_c;
    logic       cout_c;
    bcd_pair_t  pair_c;

    bcd_digit_add u_digit_add (
        .a     (A),
        .b     (B),
        .cin   (C_in),
        .units (units_c),
        .tens  (tens_c),
        .cout  (cout_c)
    );

    assign pair_c = '{tens: tens_c, units: units_c};

`ifdef SOMADOR_BCD_CHECK_EN
    logic bad_digit;
    assign bad_digit = (A > BCD_MAX) || (B > BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            saida     <= 8'h00;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                err <= bad_digit;
                if (bad_digit) begin
                    saida <= 8'h00;
                    carry <= 1'b0;
                end else begin
                    saida <= pair_c;
                    carry <= cout_c;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            saida     <= 8'h00;
            carry     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                saida <= pair_c;
                carry <= cout_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_somador_bcd_1.sv
// -----------------------------------------------------------------------------
// tb_somador_bcd_1
// Directed self-checking bench for somador_bcd_1. Follows SOMADOR_BCD_CHECK_EN
// when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_somador_bcd_1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       C_in;
    logic       out_valid;
    logic [7:0] saida;
    logic       carry;
`ifdef SOMADOR_BCD_CHECK_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    somador_bcd_1 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C_in      (C_in),
        .out_valid (out_valid),
        .saida     (saida),
        .carry     (carry)
`ifdef SOMADOR_BCD_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic r, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        C_in     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] s,
                                 input logic cy, input logic ov);
        check({tag, ".saida"},     32'(saida),     32'(s));
        check({tag, ".carry"},     32'(carry),     32'(cy));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [7:0] s;
        logic       cy;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'd0, 4'd0, 1'b0, 8'h00, 1'b0},
        '{4'd6, 4'd9, 1'b0, 8'h15, 1'b1},
        '{4'd3, 4'd3, 1'b1, 8'h07, 1'b0},
        '{4'd4, 4'd5, 1'b0, 8'h09, 1'b0},
        '{4'd8, 4'd2, 1'b0, 8'h10, 1'b1},
        '{4'd9, 4'd9, 1'b0, 8'h18, 1'b1},
        '{4'd9, 4'd9, 1'b1, 8'h19, 1'b1}
    };

    initial begin
        int s;
        logic [7:0] exp_s;

        rst = 1'b1; in_valid = 1'b1; A = 4'd0; B = 4'd0; C_in = 1'b0;

        // Reset for two cycles with random inputs on the bus.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
            expect_result("reset", 8'h00, 1'b0, 1'b0);
`ifdef SOMADOR_BCD_CHECK_EN
            check("reset.err", 32'(err), 32'd0);
`endif
        end

        // Directed vectors, back to back.
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            expect_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].cy, 1'b1);
        end

        // Hold: last result was 9+9+1 = 19.
        step(1'b0, 1'b0, 4'd1, 4'd2, 1'b0);
        expect_result("hold1", 8'h19, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        expect_result("hold2", 8'h19, 1'b1, 1'b0);

        // Reset on the same edge as a valid 7+7: result discarded.
        step(1'b0, 1'b1, 4'd2, 4'd1, 1'b0);
        expect_result("pre_rst", 8'h03, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd7, 4'd7, 1'b0);
        expect_result("rst_mid", 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
        expect_result("rst_after", 8'h00, 1'b0, 1'b0);

        // Non-BCD input 12 + 3.
        step(1'b0, 1'b1, 4'd12, 4'd3, 1'b0);
`ifdef SOMADOR_BCD_CHECK_EN
        expect_result("nonbcd", 8'h00, 1'b0, 1'b1);
        check("nonbcd.err", 32'(err), 32'd1);
`else
        expect_result("nonbcd", 8'h15, 1'b1, 1'b1);
`endif

        // Non-BCD high end: 15 + 15 + 1 = 31.
        step(1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
`ifdef SOMADOR_BCD_CHECK_EN
        expect_result("nonbcd_max", 8'h00, 1'b0, 1'b1);
        check("nonbcd_max.err", 32'(err), 32'd1);
`else
        expect_result("nonbcd_max", 8'h31, 1'b1, 1'b1);
`endif

        // Exhaustive sweep of legal combinations.
        for (int a = 0; a <= 9; a++) begin
            for (int b = 0; b <= 9; b++) begin
                for (int c = 0; c <= 1; c++) begin
                    s     = a + b + c;
                    exp_s = {4'(s / 10), 4'(s % 10)};
                    step(1'b0, 1'b1, 4'(a), 4'(b), 1'(c));
                    expect_result($sformatf("sweep_%0d_%0d_%0d", a, b, c),
                                  exp_s, 1'(s >= 10), 1'b1);
`ifdef SOMADOR_BCD_CHECK_EN
                    check("sweep.err", 32'(err), 32'd0);
`endif
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
